pipeline_stage_buffer: RTL and testbench
========================================

# pipeline_stage_buffer

Parametrised, elastic pipeline-stage register for the CPU datapath. It carries a control bundle and a datapath bundle between two pipeline stages, for example memory to writeback. It adds valid/ready handshaking with a two-entry skid buffer, synchronous flush, and bubble insertion, so stages can stall and squash without combinational ready paths. Its control outputs are forced to a safe "bubble" encoding whenever the stage holds no valid instruction.

## Interface

Parameters:
- DATA_WIDTH, default 133: datapath bundle width (ALU out 32 + write reg 5 + HI 32 + LO 32 + read data 32).
- CTRL_WIDTH, default 2: control bundle width (register_write, memory_to_register).
- CTRL_BUBBLE, default 0: value driven on out_ctrl when out_valid=0. Width CTRL_WIDTH.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream holds a valid instruction.
- in_ready  output  1  stage can accept; decoded from state register only.
- in_ctrl  input  CTRL_WIDTH  upstream control bundle.
- in_data  input  DATA_WIDTH  upstream datapath bundle.
- out_valid  output  1  downstream entry valid.
- out_ready  input  1  downstream accepts this cycle.
- out_ctrl  output  CTRL_WIDTH  control bundle; CTRL_BUBBLE when out_valid=0.
- out_data  output  DATA_WIDTH  datapath bundle.
- occupancy  output  2  entries held (0, 1 or 2).

## Operation

- Storage consists of a main register, which drives out_*, and a skid register. Each register holds ctrl and data.
- State machine with states EMPTY (0 entries), ONE (1 entry), FULL (2 entries).
- Handshake conditions:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Output decodes:
  - in_ready = (state != FULL).
  - out_valid = (state != EMPTY).
- Transitions, with no flush:
  - EMPTY: push → ONE, main ← in.
  - ONE, push & !pop: → FULL, skid ← in.
  - ONE, pop & !push: → EMPTY.
  - ONE, push & pop: stays ONE, main ← in.
  - FULL, pop: → ONE, main ← skid. push is impossible in FULL because in_ready=0.
  - Any state, neither push nor pop: hold all contents.
- Flush has the highest priority:
  - Next state is EMPTY from any state.
  - A push in the flush cycle is dropped.
  - A pop in the flush cycle still counts as consumed downstream.
  - Data registers keep their contents.
- out_ctrl is a combinational mux: main ctrl if out_valid, else CTRL_BUBBLE. No write-enable leaks from stale entries.
- out_data is the main data register value regardless of valid; it is don't-care when out_valid=0, but it must not change without a load.
- Ordering is strict FIFO; no entry is duplicated or lost.
- occupancy = 0/1/2 for EMPTY/ONE/FULL.

## Timing

- Latency: 1 cycle. A word pushed at edge N appears on out_* after edge N when the stage was EMPTY or popped simultaneously.
- Throughput: 1 word/cycle while out_ready=1.
- in_ready has no combinational path from out_ready, in_valid or flush. It changes only after a clock edge.
- While reset is asserted, with no clock needed:
  - state = EMPTY, occupancy = 0.
  - out_valid = 0, in_ready = 1, out_ctrl = CTRL_BUBBLE.
  - main and skid data/ctrl registers = 0.
- Reset asserted mid-operation, including FULL, discards all entries immediately.
- First push is possible on the first edge after reset deasserts.
- A single-cycle backpressure deassertion, with out_ready low for one cycle, costs no throughput: the skid absorbs the word.

## Test plan

- Async reset: drive the stage to FULL, assert reset between edges → out_valid=0, in_ready=1, occupancy=0, out_ctrl=CTRL_BUBBLE at once, with no edge.
- Streaming: out_ready=1, push data 1..8 with in_ctrl=2'b01 on consecutive cycles → out_data 1..8 each one cycle later, occupancy steady at 1, in_ready always 1.
- Backpressure:
  - Stimulus: out_ready=0, push A, B, then hold C at the input; release out_ready three cycles later.
  - After B: occupancy=2, in_ready=0, C not accepted.
  - After release: outputs A, B, C in order, each exactly once.
- Flush: FULL with in_valid=1 (word D) and flush=1 → next cycle occupancy=0, out_valid=0, out_ctrl=0, D dropped; D re-presented the following cycle is accepted and output.
- Simultaneous push/pop in ONE: holding X, push Y while out_ready=1 → occupancy stays 1, out_data=Y next cycle, X consumed once.
- Bubble forcing: CTRL_WIDTH=2, CTRL_BUBBLE=0, in_ctrl=2'b11 in the main register, then pop to EMPTY → out_ctrl=2'b00 while out_data still shows the last word.

Source files
------------

// File: rtl/pipeline_stage_buffer.sv
// -----------------------------------------------------------------------------
// pipeline_stage_buffer
//
// Elastic pipeline-stage register that carries a control bundle and a datapath
// bundle between two CPU pipeline stages (for example memory -> writeback).
// Upstream and downstream use a valid/ready handshake. A two-entry skid buffer
// (main + skid register) lets the stage accept a word in the same cycle that
// downstream stalls. Because of this, in_ready is decoded from the state
// register alone, and there is no combinational path from out_ready to in_ready.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset; empties the stage at once
//   flush      synchronous squash of every held entry (highest priority)
//   in_valid   upstream presents a valid instruction
//   in_ready   stage can accept a word this cycle (state-decoded)
//   in_ctrl    upstream control bundle   [CTRL_WIDTH]
//   in_data    upstream datapath bundle  [DATA_WIDTH]
//   out_valid  main register holds a valid instruction
//   out_ready  downstream accepts the word this cycle
//   out_ctrl   control bundle; forced to CTRL_BUBBLE when out_valid = 0
//   out_data   datapath bundle from the main register (don't-care if !valid)
//   occupancy  number of held entries: 0, 1 or 2
// -----------------------------------------------------------------------------
module pipeline_stage_buffer #(
  parameter int unsigned           DATA_WIDTH  = 133,
  parameter int unsigned           CTRL_WIDTH  = 2,
  parameter logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  // The encoding equals the entry count, so occupancy comes straight from it.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e state;
  state_e state_next;

  // Storage: the main register drives the outputs. The skid register takes
  // the word that arrives while downstream stalls with main already occupied.
  logic [CTRL_WIDTH-1:0] main_ctrl;
  logic [DATA_WIDTH-1:0] main_data;
  logic [CTRL_WIDTH-1:0] skid_ctrl;
  logic [DATA_WIDTH-1:0] skid_data;

  logic push;
  logic pop;
  logic load_main_in;    // main <- upstream word
  logic load_main_skid;  // main <- skid (skid drains into the output slot)
  logic load_skid;       // skid <- upstream word

  // ---------------------------------------------------------------------------
  // Handshake decodes. Both ready and valid depend only on the state register.
  // ---------------------------------------------------------------------------
  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign push      = in_valid  & in_ready;
  assign pop       = out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and load-enable decode
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first. Without the
  // defaults, a path that skips an assignment would infer a latch.
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;

    if (flush) begin
      // Squash everything. A push in this cycle is dropped (no load enables).
      // A pop is still seen by downstream, and the data registers hold.
      state_next = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (push) begin
            state_next   = ST_ONE;
            load_main_in = 1'b1;
          end
        end

        ST_ONE: begin
          unique case ({push, pop})
            2'b10: begin
              // Downstream stalled: park the new word behind the held one.
              state_next = ST_FULL;
              load_skid  = 1'b1;
            end
            2'b01: begin
              state_next = ST_EMPTY;
            end
            2'b11: begin
              // Word replaced in place: full throughput, stays ONE.
              load_main_in = 1'b1;
            end
            default: begin
              // Neither push nor pop: hold.
            end
          endcase
        end

        ST_FULL: begin
          // push cannot happen here because in_ready is low in FULL.
          if (pop) begin
            state_next     = ST_ONE;
            load_main_skid = 1'b1;
          end
        end

        default: begin
          state_next = ST_EMPTY;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Data storage
  // ---------------------------------------------------------------------------
  // NOTE: these storage registers are reset on purpose. The reset value (0)
  // is observable on out_data, so it must be defined. They load only on an
  // explicit enable, so out_data never changes without a load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end

      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Control is forced to the bubble encoding whenever the stage is empty, so a
  // stale register_write cannot reach the next stage.
  assign out_ctrl = out_valid ? main_ctrl : CTRL_BUBBLE;
  assign out_data = main_data;

  always_comb begin
    unique case (state)
      ST_EMPTY: occupancy = 2'd0;
      ST_ONE:   occupancy = 2'd1;
      ST_FULL:  occupancy = 2'd2;
      default:  occupancy = 2'd0;
    endcase
  end

`ifndef SYNTHESIS
  // Invariants: never a bubble-less empty stage, never more than two entries.
  a_bubble_when_empty : assert property (@(posedge clk) disable iff (reset)
    !out_valid |-> (out_ctrl == CTRL_BUBBLE));
  a_occupancy_range   : assert property (@(posedge clk) disable iff (reset)
    occupancy <= 2'd2);
  a_no_load_when_full : assert property (@(posedge clk) disable iff (reset)
    (state == ST_FULL) |-> !load_skid);
`endif

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stage_buffer
//
// Directed testbench for pipeline_stage_buffer with default parameters
// (DATA_WIDTH = 133, CTRL_WIDTH = 2, CTRL_BUBBLE = 0). Inputs change 1 ns
// after the rising edge, and outputs are checked in the same window.
// -----------------------------------------------------------------------------
module tb_pipeline_stage_buffer;

  localparam int DW = 133;
  localparam int CW = 2;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int total;
  int bad;

  pipeline_stage_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the handshake/status outputs against hand-computed values.
  task automatic expect_status(input string name, input logic ov, input logic ir,
                               input logic [1:0] occ);
    total++;
    if (out_valid !== ov) begin
      bad++; $display("FAIL %s out_valid got=%0b want=%0b", name, out_valid, ov);
    end
    total++;
    if (in_ready !== ir) begin
      bad++; $display("FAIL %s in_ready got=%0b want=%0b", name, in_ready, ir);
    end
    total++;
    if (occupancy !== occ) begin
      bad++; $display("FAIL %s occupancy got=%0d want=%0d", name, occupancy, occ);
    end
  endtask

  task automatic expect_word(input string name, input logic [CW-1:0] c,
                             input logic [DW-1:0] d);
    total++;
    if (out_ctrl !== c) begin
      bad++; $display("FAIL %s out_ctrl got=%0b want=%0b", name, out_ctrl, c);
    end
    total++;
    if (out_data !== d) begin
      bad++; $display("FAIL %s out_data got=%0h want=%0h", name, out_data, d);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    #3;
    expect_status("reset", 1'b0, 1'b1, 2'd0);
    expect_word("reset", 2'b00, '0);
    tick();
    reset = 1'b0;
    tick();
    expect_status("reset_idle", 1'b0, 1'b1, 2'd0);
  endtask

  task automatic test_streaming();
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 2'b01;
    for (int i = 1; i <= 8; i++) begin
      in_data = DW'(i);
      tick();
      expect_status($sformatf("stream_%0d", i), 1'b1, 1'b1, 2'd1);
      expect_word($sformatf("stream_%0d", i), 2'b01, DW'(i));
    end
    in_valid = 1'b0;
    tick();
    expect_status("stream_drain", 1'b0, 1'b1, 2'd0);
    expect_word("stream_drain", 2'b00, DW'(8));
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 2'b01;
    in_data = DW'(32'hA);
    tick();
    expect_status("bp_after_a", 1'b1, 1'b1, 2'd1);
    in_data = DW'(32'hB);
    tick();
    expect_status("bp_after_b", 1'b1, 1'b0, 2'd2);
    expect_word("bp_after_b", 2'b01, DW'(32'hA));
    in_data = DW'(32'hC);  // held at the input while stalled
    tick();
    tick();
    expect_status("bp_stall", 1'b1, 1'b0, 2'd2);
    expect_word("bp_stall", 2'b01, DW'(32'hA));
    out_ready = 1'b1;      // release: A leaves, B moves up from skid
    tick();
    expect_status("bp_rel_b", 1'b1, 1'b1, 2'd1);
    expect_word("bp_rel_b", 2'b01, DW'(32'hB));
    tick();                // B leaves, C accepted in the same cycle
    expect_status("bp_rel_c", 1'b1, 1'b1, 2'd1);
    expect_word("bp_rel_c", 2'b01, DW'(32'hC));
    in_valid = 1'b0;
    tick();                // C leaves exactly once
    expect_status("bp_done", 1'b0, 1'b1, 2'd0);
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 2'b01;
    in_data = DW'(32'hE1);
    tick();
    in_data = DW'(32'hF2);
    tick();
    expect_status("flush_full", 1'b1, 1'b0, 2'd2);
    in_data = DW'(32'hD3); flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_status("flush_empty", 1'b0, 1'b1, 2'd0);
    expect_word("flush_empty", 2'b00, DW'(32'hE1));  // data regs keep contents
    tick();                // D re-presented and accepted
    expect_status("flush_d", 1'b1, 1'b1, 2'd1);
    expect_word("flush_d", 2'b01, DW'(32'hD3));
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    expect_status("flush_drain", 1'b0, 1'b1, 2'd0);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 2'b10;
    in_data = DW'(32'h1234_5678);
    tick();
    expect_word("b2b_x", 2'b10, DW'(32'h1234_5678));
    out_ready = 1'b1; in_data = {5'h1f, 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D};
    tick();
    expect_status("b2b_y", 1'b1, 1'b1, 2'd1);
    expect_word("b2b_y", 2'b10, {5'h1f, 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D});
    in_valid = 1'b0;
    tick();
    expect_status("b2b_drain", 1'b0, 1'b1, 2'd0);
  endtask

  task automatic test_bubble();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 2'b11; in_data = DW'(32'h77);
    tick();
    expect_word("bubble_held", 2'b11, DW'(32'h77));
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    expect_status("bubble_empty", 1'b0, 1'b1, 2'd0);
    expect_word("bubble_empty", 2'b00, DW'(32'h77));
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 2'b01;
    in_data = DW'(32'h51);
    tick();
    in_data = DW'(32'h52);
    tick();
    expect_status("areset_full", 1'b1, 1'b0, 2'd2);
    in_valid = 1'b0;
    #2 reset = 1'b1;       // between edges
    #1;
    expect_status("areset_now", 1'b0, 1'b1, 2'd0);
    expect_word("areset_now", 2'b00, '0);
    #1 reset = 1'b0;
    in_valid = 1'b1; in_ctrl = 2'b01; in_data = DW'(32'h99);
    tick();                // first edge after release accepts a push
    expect_status("areset_first", 1'b1, 1'b1, 2'd1);
    expect_word("areset_first", 2'b01, DW'(32'h99));
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_bubble();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
